// File: rtl/clk_mgr_pkg.sv
// Shared types and defaults for the clock manager: FSM encoding and divider width.
package clk_mgr_pkg;

    localparam int unsigned DIV_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_STABLE    = 2'd1,
        ST_RUN       = 2'd2
    } state_e;

endpackage

// File: rtl/clk_div_ch.sv
// One clock-enable channel: divisor register, phase counter and registered ce strobe.
module clk_div_ch
    import clk_mgr_pkg::*;
#(
    parameter int unsigned      DIV_W    = DIV_W_DEF,
    parameter logic [DIV_W-1:0] DIV_INIT = '0
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             run_i,
    input  logic             run_nxt_i,
    input  logic             upd_i,
    input  logic [DIV_W-1:0] upd_div_i,
    output logic             apply_c_o,
    output logic             ce_o
);

    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             ce_q, ce_d;
    logic             wrap_c;

    assign wrap_c    = (div_q != '0) && (cnt_q == div_q - DIV_W'(1));
    // A pending divisor lands on the wrap cycle, or at once when the channel is idle.
    assign apply_c_o = upd_i && (!run_i || (div_q == '0) || wrap_c);

    always_comb begin
        div_d = div_q;
        cnt_d = '0;
        ce_d  = 1'b0;
        if (apply_c_o) begin
            div_d = upd_div_i;
        end
        if (run_i && run_nxt_i && (div_q != '0) && !wrap_c) begin
            cnt_d = cnt_q + DIV_W'(1);
        end
        ce_d = run_nxt_i && (div_d != '0) && (cnt_d == div_d - DIV_W'(1));
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            div_q <= DIV_INIT;
            cnt_q <= '0;
            ce_q  <= 1'b0;
        end else begin
            div_q <= div_d;
            cnt_q <= cnt_d;
            ce_q  <= ce_d;
        end
    end

    assign ce_o = ce_q;

endmodule

// File: rtl/clk_mgr.sv
// Clock manager: PLL lock qualification, downstream reset release and divided clock enables.
module clk_mgr
    import clk_mgr_pkg::*;
#(
    parameter int unsigned            N_CH     = 3,
    parameter int unsigned            DIV_W    = DIV_W_DEF,
    parameter logic [N_CH*DIV_W-1:0]  DIV_INIT = {8'd4, 8'd3, 8'd1},
    parameter int unsigned            LOCK_CYC = 16
) (
    input  logic                                    clk_i,
    input  logic                                    rst_n_i,
    input  logic                                    pll_lock_i,
    output logic                                    rst_n_o,
    output logic                                    locked_o,
    output logic [N_CH-1:0]                         ce_o,
    input  logic                                    cfg_valid_i,
    input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] cfg_ch_i,
    input  logic [DIV_W-1:0]                        cfg_div_i,
    output logic                                    cfg_ready_o
);

    localparam int unsigned CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned SCNT_W = $clog2(LOCK_CYC + 1);

    logic              sync1_q, lock_s_q;
    state_e            state_q, state_d;
    logic [SCNT_W-1:0] scnt_q, scnt_d;
    logic              run_q, run_d;
    logic              pend_q, pend_d;
    logic [CH_W-1:0]   pch_q, pch_d;
    logic [DIV_W-1:0]  pdiv_q, pdiv_d;
    logic [N_CH-1:0]   apply_c;

    // Two-flop synchroniser for the asynchronous PLL lock.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q  <= 1'b0;
            lock_s_q <= 1'b0;
        end else begin
            sync1_q  <= pll_lock_i;
            lock_s_q <= sync1_q;
        end
    end

    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        unique case (state_q)
            ST_WAIT_LOCK: begin
                if (lock_s_q) begin
                    state_d = ST_STABLE;
                    scnt_d  = '0;
                end
            end
            ST_STABLE: begin
                if (!lock_s_q) begin
                    state_d = ST_WAIT_LOCK;
                end else if (scnt_q == SCNT_W'(LOCK_CYC - 1)) begin
                    state_d = ST_RUN;
                end else begin
                    scnt_d = scnt_q + SCNT_W'(1);
                end
            end
            ST_RUN: begin
                if (!lock_s_q) begin
                    state_d = ST_WAIT_LOCK;
                end
            end
            default: state_d = ST_WAIT_LOCK;
        endcase
        run_d = (state_d == ST_RUN);
    end

    // Single global update slot; out-of-range channels are swallowed without occupying it.
    always_comb begin
        pend_d = pend_q;
        pch_d  = pch_q;
        pdiv_d = pdiv_q;
        if (pend_q) begin
            if (|apply_c) begin
                pend_d = 1'b0;
            end
        end else if (cfg_valid_i && (32'(cfg_ch_i) < N_CH)) begin
            pend_d = 1'b1;
            pch_d  = cfg_ch_i;
            pdiv_d = cfg_div_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_WAIT_LOCK;
            scnt_q  <= '0;
            run_q   <= 1'b0;
            pend_q  <= 1'b0;
            pch_q   <= '0;
            pdiv_q  <= '0;
        end else begin
            state_q <= state_d;
            scnt_q  <= scnt_d;
            run_q   <= run_d;
            pend_q  <= pend_d;
            pch_q   <= pch_d;
            pdiv_q  <= pdiv_d;
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        clk_div_ch #(
            .DIV_W    (DIV_W),
            .DIV_INIT (DIV_INIT[c*DIV_W +: DIV_W])
        ) u_ch (
            .clk_i     (clk_i),
            .rst_n_i   (rst_n_i),
            .run_i     (run_q),
            .run_nxt_i (run_d),
            .upd_i     (pend_q && (pch_q == CH_W'(c))),
            .upd_div_i (pdiv_q),
            .apply_c_o (apply_c[c]),
            .ce_o      (ce_o[c])
        );
    end

    assign rst_n_o     = run_q;
    assign locked_o    = run_q;
    assign cfg_ready_o = ~pend_q;

endmodule

// File: tb/tb_clk_mgr.sv
// Bench for clk_mgr: cycle model feeding an expectation queue, a segment table and timing sequences.
module tb_clk_mgr;

    localparam int N_CH     = 3;
    localparam int LOCK_CYC = 16;

    typedef struct packed {
        logic       rstn;
        logic       lk;
        logic [2:0] ce;
        logic       rdy;
    } obs_t;

    typedef struct {
        int   ncyc;
        bit   lock;
        bit   vld;
        int   ch;
        int   dv;
        logic exp_locked;
    } seg_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       lock = 1'b0;
    logic       v = 1'b0;
    logic [1:0] ch = '0;
    logic [7:0] dv = '0;
    logic       rst_n_o, locked_o, cfg_ready_o;
    logic [2:0] ce_o;

    int n_chk = 0;
    int n_fail = 0;

    obs_t exp_q[$];

    int m_st, m_scnt, m_pch, m_pdiv;
    bit m_s1, m_s2, m_pend;
    int m_cnt[N_CH];
    int m_div[N_CH];
    obs_t m_out;

    clk_mgr dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .pll_lock_i  (lock),
        .rst_n_o     (rst_n_o),
        .locked_o    (locked_o),
        .ce_o        (ce_o),
        .cfg_valid_i (v),
        .cfg_ch_i    (ch),
        .cfg_div_i   (dv),
        .cfg_ready_o (cfg_ready_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%b exp=%b", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_scnt = 0; m_s1 = 0; m_s2 = 0;
        m_pend = 0; m_pch = 0; m_pdiv = 0;
        for (int c = 0; c < N_CH; c++) m_cnt[c] = 0;
        m_div[0] = 1; m_div[1] = 3; m_div[2] = 4;
    endtask

    // Reference behaviour for one clock edge given the inputs presented before it.
    task automatic model_step(input bit l, input bit vv, input int c_in, input int d_in);
        int nst, nscnt;
        bit nrun, any_ap, ap;
        int ndiv[N_CH];
        int ncnt[N_CH];
        bit nce[N_CH];
        nst = m_st; nscnt = m_scnt; any_ap = 0;
        if (m_st == 0) begin
            if (m_s2) begin nst = 1; nscnt = 0; end
        end else if (m_st == 1) begin
            if (!m_s2) nst = 0;
            else if (m_scnt == LOCK_CYC - 1) nst = 2;
            else nscnt = m_scnt + 1;
        end else begin
            if (!m_s2) nst = 0;
        end
        nrun = (nst == 2);
        for (int c = 0; c < N_CH; c++) begin
            ap = m_pend && (m_pch == c) &&
                 (m_st != 2 || m_div[c] == 0 || m_cnt[c] == m_div[c] - 1);
            any_ap |= ap;
            ndiv[c] = ap ? m_pdiv : m_div[c];
            ncnt[c] = (m_st == 2 && nrun && m_div[c] != 0 && m_cnt[c] != m_div[c] - 1)
                      ? m_cnt[c] + 1 : 0;
            nce[c]  = nrun && ndiv[c] != 0 && ncnt[c] == ndiv[c] - 1;
        end
        if (m_pend) begin
            if (any_ap) m_pend = 0;
        end else if (vv && c_in < N_CH) begin
            m_pend = 1; m_pch = c_in; m_pdiv = d_in;
        end
        m_s2 = m_s1; m_s1 = l;
        m_st = nst; m_scnt = nscnt;
        for (int c = 0; c < N_CH; c++) begin
            m_div[c] = ndiv[c];
            m_cnt[c] = ncnt[c];
        end
        m_out = '{rstn: nrun, lk: nrun, ce: {nce[2], nce[1], nce[0]}, rdy: !m_pend};
    endtask

    task automatic cyc(input bit l, input bit vv, input int c_in, input int d_in);
        obs_t got, e;
        lock = l; v = vv; ch = 2'(c_in); dv = 8'(d_in);
        model_step(l, vv, c_in, d_in);
        exp_q.push_back(m_out);
        @(posedge clk);
        #1;
        got = '{rstn: rst_n_o, lk: locked_o, ce: ce_o, rdy: cfg_ready_o};
        if (exp_q.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check("sb", 32'(got), 32'(e));
        end
        v = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; v = 1'b0; lock = 1'b0;
        #1;
        check("rst_vals", 32'({rst_n_o, locked_o, ce_o, cfg_ready_o}), 32'(6'b000001));
        model_reset();
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Holds lock high until release; reports edges from first lock sample to RUN.
    task automatic wait_run();
        int n;
        n = -1;
        for (int i = 0; i < 60; i++) begin
            cyc(1, 0, 0, 0);
            if (rst_n_o) begin n = i; break; end
        end
        check("rise_delay", 32'(n), 32'(2 + LOCK_CYC));
    endtask

    // Called while observing RUN cycle 1; captures ce over RUN cycles 1..6.
    task automatic phases(input string tag);
        logic [5:0] m0, m1, m2;
        m0 = '0; m1 = '0; m2 = '0;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) cyc(1, 0, 0, 0);
            m0[k] = ce_o[0]; m1[k] = ce_o[1]; m2[k] = ce_o[2];
        end
        check({tag, "_ce0"}, 32'(m0), 32'(6'b111111));
        check({tag, "_ce1"}, 32'(m1), 32'(6'b100100));
        check({tag, "_ce2"}, 32'(m2), 32'(6'b001000));
    endtask

    initial begin
        seg_t tbl[10];
        int n;
        logic [11:0] mce, mrdy;
        logic [7:0]  quiet;

        tbl[0] = '{4,  0, 0, 0, 0, 1'b0};
        tbl[1] = '{25, 1, 0, 0, 0, 1'b1};
        tbl[2] = '{1,  1, 1, 3, 9, 1'b1};
        tbl[3] = '{6,  1, 1, 0, 2, 1'b1};
        tbl[4] = '{5,  1, 0, 0, 0, 1'b1};
        tbl[5] = '{3,  0, 0, 0, 0, 1'b0};
        tbl[6] = '{2,  0, 1, 2, 3, 1'b0};
        tbl[7] = '{22, 1, 0, 0, 0, 1'b1};
        tbl[8] = '{10, 1, 1, 1, 1, 1'b1};
        tbl[9] = '{4,  0, 0, 0, 0, 1'b0};

        #2;
        do_reset();

        // Lock rises on cycle 5; release timing and default ce phases.
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
        wait_run();
        phases("init");

        // Short lock glitch mid-count restarts the full qualification.
        do_reset();
        for (int i = 0; i < 12; i++) cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        wait_run();
        phases("glitch");

        // Lock loss in RUN, then relock restarts phases from zero.
        n = -1;
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 0, 0);
            if ({rst_n_o, locked_o, ce_o} == 5'b0) begin n = i; break; end
        end
        check("drop_within3", 32'(n >= 0 && n <= 2), 32'd1);
        wait_run();
        phases("relock");

        // ch1 -> 5 written when its counter is 0: old period completes first.
        cyc(1, 0, 0, 0);
        mce = '0; mrdy = '0;
        for (int j = 0; j < 12; j++) begin
            if (j == 0) cyc(1, 1, 1, 5); else cyc(1, 0, 0, 0);
            mce[j] = ce_o[1]; mrdy[j] = cfg_ready_o;
        end
        check("ch1_d5_ce", 32'(mce), 32'(12'b1000_0100_0010));
        check("ch1_d5_rdy", 32'(mrdy), 32'(12'b1111_1111_1100));

        // ch2 disabled, then re-enabled with d=2.
        cyc(1, 1, 2, 0);
        n = -1;
        for (int i = 0; i < 10; i++) begin
            cyc(1, 0, 0, 0);
            if (cfg_ready_o) begin n = i; break; end
        end
        check("ch2_d0_ready", 32'(n >= 0), 32'd1);
        quiet = '0;
        for (int i = 0; i < 8; i++) begin
            cyc(1, 0, 0, 0);
            quiet[i] = ce_o[2];
        end
        check("ch2_silent", 32'(quiet), 32'd0);
        mce = '0; mrdy = '0;
        for (int j = 0; j < 6; j++) begin
            if (j == 0) cyc(1, 1, 2, 2); else cyc(1, 0, 0, 0);
            mce[j] = ce_o[2]; mrdy[j] = cfg_ready_o;
        end
        check("ch2_d2_ce", 32'(mce[5:0]), 32'(6'b010100));
        check("ch2_d2_rdy", 32'(mrdy[5:0]), 32'(6'b111110));

        // Reset while an update is pending restores everything.
        cyc(1, 1, 1, 7);
        check("pend_before_rst", 32'(cfg_ready_o), 32'd0);
        do_reset();
        wait_run();
        phases("post_rst");

        // Segment table, every cycle also checked against the model.
        do_reset();
        for (int s = 0; s < 10; s++) begin
            for (int k = 0; k < tbl[s].ncyc; k++) begin
                cyc(tbl[s].lock, tbl[s].vld, tbl[s].ch, tbl[s].dv);
            end
            check($sformatf("seg%0d_locked", s), 32'(locked_o), 32'(tbl[s].exp_locked));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
